// File: rtl/register_file_mp_pkg.sv
// Shared constants, select type and index validity helper for the register file.
package regfile_pkg;

    localparam int unsigned SEL_W   = 4;
    localparam int unsigned NUM_IDX = 1 << SEL_W;

    typedef logic [SEL_W-1:0] sel_t;

    localparam sel_t SP_IDX = 4'd13;
    localparam sel_t LR_IDX = 4'd14;

    // An index is backed by storage if it is a GPR, SP or LR.
    function automatic logic is_valid_idx(input sel_t sel, input int unsigned num_gpr);
        return (32'(sel) < num_gpr) || (sel == SP_IDX) || (sel == LR_IDX);
    endfunction

endpackage

// File: rtl/register_file_mp_if.sv
// Decode/writeback-facing bus of the multi-port register file.
interface register_file_mp_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NUM_RD = 2,
    parameter int unsigned SEL_W  = 4
);
    logic                       stall_i;
    logic [NUM_RD*SEL_W-1:0]    rd_sel_i;
    logic [NUM_RD*DATA_W-1:0]   rd_data_o;
    logic [NUM_RD-1:0]          rd_ready_o;
    logic [1:0]                 wr_en_i;
    logic [2*SEL_W-1:0]         wr_sel_i;
    logic [2*DATA_W-1:0]        wr_data_i;
    logic                       sp_wr_en_i;
    logic [DATA_W-1:0]          sp_data_i;
    logic                       claim_en_i;
    logic [SEL_W-1:0]           claim_sel_i;
    logic [(1<<SEL_W)-1:0]      busy_o;

    modport master (
        output stall_i, rd_sel_i, wr_en_i, wr_sel_i, wr_data_i,
               sp_wr_en_i, sp_data_i, claim_en_i, claim_sel_i,
        input  rd_data_o, rd_ready_o, busy_o
    );

    modport slave (
        input  stall_i, rd_sel_i, wr_en_i, wr_sel_i, wr_data_i,
               sp_wr_en_i, sp_data_i, claim_en_i, claim_sel_i,
        output rd_data_o, rd_ready_o, busy_o
    );
endinterface

// File: rtl/register_file_mp_scoreboard.sv
// Pending-write scoreboard: writebacks clear, decode claims set, claims win ties.
module reg_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned NUM_GPR = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         wr_en_i,
    input  logic [2*SEL_W-1:0] wr_sel_i,
    input  logic               sp_wr_en_i,
    input  logic               claim_en_i,
    input  sel_t               claim_sel_i,
    output logic [NUM_IDX-1:0] busy_o,
    output logic [NUM_IDX-1:0] busy_clr_c
);

    logic [NUM_IDX-1:0] busy_q;
    logic [NUM_IDX-1:0] busy_d;

    // Clears first (used for read readiness), then the claim on top.
    always_comb begin
        busy_clr_c = busy_q;
        for (int w = 0; w < 2; w++) begin
            if (wr_en_i[w] && is_valid_idx(sel_t'(wr_sel_i[w*SEL_W +: SEL_W]), NUM_GPR)) begin
                busy_clr_c[wr_sel_i[w*SEL_W +: SEL_W]] = 1'b0;
            end
        end
        if (sp_wr_en_i) begin
            busy_clr_c[SP_IDX] = 1'b0;
        end
        busy_d = busy_clr_c;
        if (claim_en_i && is_valid_idx(claim_sel_i, NUM_GPR)) begin
            busy_d[claim_sel_i] = 1'b1;
        end
    end

    // Busy vector register.
    always_ff @(posedge clk) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file: GPRs + SP/LR, write-first bypass, registered reads.
module register_file_mp
    import regfile_pkg::*;
#(
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       NUM_GPR  = 8,
    parameter int unsigned       NUM_RD   = 2,
    parameter logic [DATA_W-1:0] SP_RESET = 32'h0000_1FFE,
    parameter logic [DATA_W-1:0] LR_RESET = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    register_file_mp_if.slave  bus
);

    logic [DATA_W-1:0]  regs_q [NUM_IDX];
    logic [DATA_W-1:0]  regs_d [NUM_IDX];
    logic [NUM_IDX-1:0] busy_clr_c;

    reg_scoreboard #(.NUM_GPR(NUM_GPR)) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .wr_en_i     (bus.wr_en_i),
        .wr_sel_i    (bus.wr_sel_i),
        .sp_wr_en_i  (bus.sp_wr_en_i),
        .claim_en_i  (bus.claim_en_i),
        .claim_sel_i (bus.claim_sel_i),
        .busy_o      (bus.busy_o),
        .busy_clr_c  (busy_clr_c)
    );

    // Post-write register image; later assignments carry higher priority.
    always_comb begin
        regs_d = regs_q;
        for (int w = 0; w < 2; w++) begin
            if (bus.wr_en_i[w] && is_valid_idx(sel_t'(bus.wr_sel_i[w*SEL_W +: SEL_W]), NUM_GPR)) begin
                regs_d[bus.wr_sel_i[w*SEL_W +: SEL_W]] = bus.wr_data_i[w*DATA_W +: DATA_W];
            end
        end
        if (bus.sp_wr_en_i) begin
            regs_d[SP_IDX] = bus.sp_data_i;
        end
    end

    // Register storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_IDX); i++) begin
                if (sel_t'(i) == SP_IDX)      regs_q[i] <= SP_RESET;
                else if (sel_t'(i) == LR_IDX) regs_q[i] <= LR_RESET;
                else                          regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        sel_t              sel;
        logic [DATA_W-1:0] data_q;
        logic [DATA_W-1:0] data_d;
        logic              ready_q;
        logic              ready_d;

        assign sel = sel_t'(bus.rd_sel_i[p*SEL_W +: SEL_W]);

        // Read port: bypassed data and post-clear readiness, held under stall.
        always_comb begin
            data_d  = data_q;
            ready_d = ready_q;
            if (!bus.stall_i) begin
                if (is_valid_idx(sel, NUM_GPR)) begin
                    data_d  = regs_d[sel];
                    ready_d = ~busy_clr_c[sel];
                end else begin
                    data_d  = '0;
                    ready_d = 1'b1;
                end
            end
        end

        // Read output registers.
        always_ff @(posedge clk) begin
            if (rst) begin
                data_q  <= '0;
                ready_q <= 1'b0;
            end else begin
                data_q  <= data_d;
                ready_q <= ready_d;
            end
        end

        assign bus.rd_data_o[p*DATA_W +: DATA_W] = data_q;
        assign bus.rd_ready_o[p]                 = ready_q;
    end

endmodule

// File: tb/tb_register_file_mp.sv
// Directed self-checking bench for register_file_mp.
module tb_register_file_mp;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    register_file_mp_if #(.DATA_W(32), .NUM_RD(2), .SEL_W(4)) bus ();

    register_file_mp dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.stall_i     = 1'b0;
        bus.wr_en_i     = 2'b00;
        bus.wr_sel_i    = '0;
        bus.wr_data_i   = '0;
        bus.sp_wr_en_i  = 1'b0;
        bus.sp_data_i   = '0;
        bus.claim_en_i  = 1'b0;
        bus.claim_sel_i = '0;
    endtask

    task automatic rd(input logic [3:0] s1, input logic [3:0] s0);
        bus.rd_sel_i = {s1, s0};
    endtask

    initial begin
        checks = 0;
        errors = 0;
        idle();
        rd(4'd0, 4'd0);
        rst = 1'b1;
        step();
        chk("reset_busy",  64'(bus.busy_o), 64'h0);
        chk("reset_data",  bus.rd_data_o, 64'h0);
        chk("reset_ready", 64'(bus.rd_ready_o), 64'h0);

        // SP / LR reset values
        rst = 1'b0;
        rd(4'd14, 4'd13);
        step();
        chk("sp_lr_data",  bus.rd_data_o, {32'h0, 32'h0000_1FFE});
        chk("sp_lr_ready", 64'(bus.rd_ready_o), 64'h3);
        chk("sp_lr_busy",  64'(bus.busy_o), 64'h0);

        // Same-cycle write-to-read bypass
        bus.wr_en_i = 2'b01; bus.wr_sel_i = {4'd0, 4'd3}; bus.wr_data_i = {32'h0, 32'hA5A5_0003};
        rd(4'd3, 4'd3);
        step();
        chk("bypass_r3", bus.rd_data_o, {32'hA5A5_0003, 32'hA5A5_0003});

        // Port 1 beats port 0 on the same index
        bus.wr_en_i = 2'b11; bus.wr_sel_i = {4'd5, 4'd5}; bus.wr_data_i = {32'h2222, 32'h1111};
        rd(4'd5, 4'd5);
        step();
        chk("prio_r5_bypass", bus.rd_data_o, {32'h2222, 32'h2222});

        // Dedicated SP write beats a generic write to index 13
        bus.wr_en_i = 2'b01; bus.wr_sel_i = {4'd0, 4'd13}; bus.wr_data_i = {32'h0, 32'h5555};
        bus.sp_wr_en_i = 1'b1; bus.sp_data_i = 32'h3000;
        rd(4'd5, 4'd13);
        step();
        chk("prio_sp_bypass", bus.rd_data_o, {32'h2222, 32'h3000});
        idle();
        step();
        chk("prio_stored", bus.rd_data_o, {32'h2222, 32'h3000});

        // Claim r2: same-cycle claim does not affect readiness
        bus.claim_en_i = 1'b1; bus.claim_sel_i = 4'd2;
        rd(4'd0, 4'd2);
        step();
        chk("claim_ready_same", 64'(bus.rd_ready_o), 64'h3);
        chk("claim_busy",       64'(bus.busy_o), 64'h4);
        idle();
        step();
        chk("claim_ready_next", 64'(bus.rd_ready_o), 64'h2);

        // Writeback in the read cycle: ready with bypassed data
        bus.wr_en_i = 2'b10; bus.wr_sel_i = {4'd2, 4'd0}; bus.wr_data_i = {32'h42, 32'h0};
        step();
        chk("wb_ready", 64'(bus.rd_ready_o), 64'h3);
        chk("wb_data0", 64'(bus.rd_data_o[31:0]), 64'h42);
        chk("wb_busy",  64'(bus.busy_o), 64'h0);

        // Claim and writeback of r2 together: claim wins
        bus.wr_en_i = 2'b01; bus.wr_sel_i = {4'd0, 4'd2}; bus.wr_data_i = {32'h0, 32'h43};
        bus.claim_en_i = 1'b1; bus.claim_sel_i = 4'd2;
        step();
        chk("claim_wb_busy", 64'(bus.busy_o), 64'h4);
        chk("claim_wb_data", 64'(bus.rd_data_o[31:0]), 64'h43);

        // Establish non-trivial outputs before stalling
        idle();
        rd(4'd2, 4'd5);
        step();
        chk("pre_stall_data",  bus.rd_data_o, {32'h43, 32'h2222});
        chk("pre_stall_ready", 64'(bus.rd_ready_o), 64'h1);

        // Stall for three cycles while writing r1 and moving selects
        for (int i = 0; i < 3; i++) begin
            bus.stall_i = 1'b1;
            bus.wr_en_i = 2'b01; bus.wr_sel_i = {4'd0, 4'd1}; bus.wr_data_i = {32'h0, 32'h77};
            rd(4'd1, 4'(i + 6));
            step();
            chk("stall_data",  bus.rd_data_o, {32'h43, 32'h2222});
            chk("stall_ready", 64'(bus.rd_ready_o), 64'h1);
        end
        idle();
        rd(4'd1, 4'd1);
        step();
        chk("unstall_r1",    bus.rd_data_o, {32'h77, 32'h77});
        chk("unstall_ready", 64'(bus.rd_ready_o), 64'h3);

        // Claim r4, write r6
        bus.claim_en_i = 1'b1; bus.claim_sel_i = 4'd4;
        step();
        chk("claim_r4_busy", 64'(bus.busy_o), 64'h14);
        idle();
        bus.wr_en_i = 2'b10; bus.wr_sel_i = {4'd6, 4'd0}; bus.wr_data_i = {32'h66, 32'h0};
        rd(4'd6, 4'd6);
        step();
        chk("r6_written", bus.rd_data_o, {32'h66, 32'h66});

        // Reset mid-sequence with stall and claim active
        idle();
        bus.stall_i = 1'b1;
        bus.claim_en_i = 1'b1; bus.claim_sel_i = 4'd7;
        rst = 1'b1;
        step();
        chk("rst2_busy",  64'(bus.busy_o), 64'h0);
        chk("rst2_data",  bus.rd_data_o, 64'h0);
        chk("rst2_ready", 64'(bus.rd_ready_o), 64'h0);
        rst = 1'b0;
        idle();
        rd(4'd9, 4'd6);
        step();
        chk("rst2_r6_sel9", bus.rd_data_o, 64'h0);
        chk("sel9_ready",   64'(bus.rd_ready_o), 64'h3);

        // Writes and claims to invalid indices are dropped
        bus.wr_en_i = 2'b11; bus.wr_sel_i = {4'd9, 4'd15}; bus.wr_data_i = {32'hBEEF, 32'hDEAD};
        bus.claim_en_i = 1'b1; bus.claim_sel_i = 4'd15;
        rd(4'd9, 4'd15);
        step();
        chk("inv_data",  bus.rd_data_o, 64'h0);
        chk("inv_ready", 64'(bus.rd_ready_o), 64'h3);
        chk("inv_busy",  64'(bus.busy_o), 64'h0);
        idle();
        rd(4'd13, 4'd0);
        step();
        chk("post_inv_r0_sp", bus.rd_data_o, {32'h0000_1FFE, 32'h0});
        chk("post_inv_busy",  64'(bus.busy_o), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
